// File: rtl/kernel3x3_filter_pkg.sv
// Shared definitions for the 3x3 kernel filter: mode encoding, kernel
// coefficients and the saturating clip helper.
package filter_pkg;

  typedef enum logic [2:0] {
    MODE_PASS    = 3'd0,
    MODE_SOBEL_X = 3'd1,
    MODE_SOBEL_Y = 3'd2,
    MODE_GRAD    = 3'd3,
    MODE_GAUSS   = 3'd4
  } filter_mode_e;

  // Indexed [row][col]; Sobel Y is applied as the transpose of SOBEL_X.
  localparam int SOBEL_X [3][3] = '{'{-32'sd1, 32'sd0, 32'sd1},
                                    '{-32'sd2, 32'sd0, 32'sd2},
                                    '{-32'sd1, 32'sd0, 32'sd1}};

  localparam int GAUSS_K [3][3] = '{'{32'sd1, 32'sd2, 32'sd1},
                                    '{32'sd2, 32'sd4, 32'sd2},
                                    '{32'sd1, 32'sd2, 32'sd1}};

  localparam int GAUSS_SHIFT = 32'sd4;

  function automatic int clip_sat(input int value, input int dw);
    int max_v;
    max_v = (32'sd1 <<< dw) - 32'sd1;
    if (value < 32'sd0) begin
      clip_sat = 32'sd0;
    end else if (value > max_v) begin
      clip_sat = max_v;
    end else begin
      clip_sat = value;
    end
  endfunction

endpackage

// File: rtl/kernel3x3_filter_line_buffer.sv
// Single-clock line memory: combinational read of the old word, write at
// the clock edge, so a same-address access returns the previous line.
module line_buffer
  import filter_pkg::*;
#(
  parameter int DEPTH = 1600,
  parameter int WIDTH = 24
) (
  input  logic                     CLK,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  assign rd_data = mem_r[addr];

  // Contents are intentionally left unreset; the border mask hides stale lines.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_r[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/kernel3x3_filter.sv
// Streaming 3x3 kernel filter: window shift, arithmetic and clip/mux stages,
// one output beat per input beat with a fixed 3-cycle latency.
module kernel3x3_filter
  import filter_pkg::*;
#(
  parameter int IMG_W = 1600,
  parameter int IMG_H = 900,
  parameter int DW    = 8,
  parameter int NCH   = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [2:0]        MODE,
  input  logic              IN_VALID,
  input  logic              IN_SOF,
  input  logic [NCH*DW-1:0] IN_DATA,
  output logic              OUT_VALID,
  output logic              OUT_SOF,
  output logic              OUT_EOL,
  output logic [NCH*DW-1:0] OUT_DATA
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int AW = DW + 4;
  localparam int PW = NCH * DW;

  logic [XW-1:0] x_r, x_cur_s;
  logic [YW-1:0] y_r, y_cur_s;
  logic [2:0]    mode_r, beat_mode_s;
  logic          frame_start_s;

  // Position of the current beat; SOF overrides the running counters.
  always_comb begin
    x_cur_s = x_r;
    y_cur_s = y_r;
    if (IN_VALID && IN_SOF) begin
      x_cur_s = '0;
      y_cur_s = '0;
    end else begin
      x_cur_s = x_r;
      y_cur_s = y_r;
    end
    frame_start_s = (x_cur_s == '0) && (y_cur_s == '0);
    beat_mode_s   = frame_start_s ? MODE : mode_r;
  end

  // Pixel counters and the frame-latched mode.
  always_ff @(posedge CLK) begin
    if (RST) begin
      x_r    <= '0;
      y_r    <= '0;
      mode_r <= 3'd0;
    end else if (IN_VALID) begin
      mode_r <= beat_mode_s;
      if (x_cur_s == XW'(IMG_W - 1)) begin
        x_r <= '0;
        y_r <= (y_cur_s == YW'(IMG_H - 1)) ? '0 : y_cur_s + YW'(1'b1);
      end else begin
        x_r <= x_cur_s + XW'(1'b1);
        y_r <= y_cur_s;
      end
    end
  end

  logic [PW-1:0] row1_s, row2_s;

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PW)) u_lb_row1 (
    .CLK     (CLK),
    .wr_en   (IN_VALID),
    .addr    (x_cur_s),
    .wr_data (IN_DATA),
    .rd_data (row1_s)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PW)) u_lb_row2 (
    .CLK     (CLK),
    .wr_en   (IN_VALID),
    .addr    (x_cur_s),
    .wr_data (row1_s),
    .rd_data (row2_s)
  );

  // Window indexed [ch][row][col]; row 2 is the current line, col 2 the newest pixel.
  logic [DW-1:0] win_r [NCH][3][3];
  logic          v1_r, sof1_r, eol1_r, border1_r;
  logic [2:0]    mode1_r;

  // Stage 1: shift the window one column per accepted beat.
  always_ff @(posedge CLK) begin
    if (RST) begin
      v1_r      <= 1'b0;
      sof1_r    <= 1'b0;
      eol1_r    <= 1'b0;
      border1_r <= 1'b0;
      mode1_r   <= 3'd0;
      for (int ch = 0; ch < NCH; ch++) begin
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < 3; c++) begin
            win_r[ch][r][c] <= '0;
          end
        end
      end
    end else begin
      v1_r <= IN_VALID;
      if (IN_VALID) begin
        sof1_r    <= frame_start_s;
        eol1_r    <= (x_cur_s == XW'(IMG_W - 1));
        border1_r <= (x_cur_s < XW'(2)) || (y_cur_s < YW'(2));
        mode1_r   <= beat_mode_s;
        for (int ch = 0; ch < NCH; ch++) begin
          for (int r = 0; r < 3; r++) begin
            win_r[ch][r][0] <= win_r[ch][r][1];
            win_r[ch][r][1] <= win_r[ch][r][2];
          end
          win_r[ch][0][2] <= row2_s[(NCH-1-ch)*DW +: DW];
          win_r[ch][1][2] <= row1_s[(NCH-1-ch)*DW +: DW];
          win_r[ch][2][2] <= IN_DATA[(NCH-1-ch)*DW +: DW];
        end
      end
    end
  end

  logic signed [AW-1:0] gx_s [NCH];
  logic signed [AW-1:0] gy_s [NCH];
  logic signed [AW-1:0] grad_s [NCH];
  logic signed [AW-1:0] gauss_s [NCH];
  logic        [AW-1:0] gsum_s [NCH];
  logic signed [AW-1:0] pix_s;

  // Stage 2 arithmetic: all kernels evaluated in parallel at AW bits.
  always_comb begin
    pix_s = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      gx_s[ch]   = '0;
      gy_s[ch]   = '0;
      gsum_s[ch] = '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          pix_s      = $signed({4'b0000, win_r[ch][r][c]});
          gx_s[ch]   = gx_s[ch] + AW'(SOBEL_X[r][c]) * pix_s;
          gy_s[ch]   = gy_s[ch] + AW'(SOBEL_X[c][r]) * pix_s;
          gsum_s[ch] = gsum_s[ch] + AW'(GAUSS_K[r][c]) * AW'(win_r[ch][r][c]);
        end
      end
      grad_s[ch]  = (gx_s[ch][AW-1] ? -gx_s[ch] : gx_s[ch])
                  + (gy_s[ch][AW-1] ? -gy_s[ch] : gy_s[ch]);
      gauss_s[ch] = $signed(gsum_s[ch] >> GAUSS_SHIFT);
    end
  end

  logic signed [AW-1:0] gx2_r [NCH];
  logic signed [AW-1:0] gy2_r [NCH];
  logic signed [AW-1:0] grad2_r [NCH];
  logic signed [AW-1:0] gauss2_r [NCH];
  logic        [DW-1:0] centre2_r [NCH];
  logic                 v2_r, sof2_r, eol2_r, border2_r;
  logic [2:0]           mode2_r;

  // Stage 2 register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      v2_r      <= 1'b0;
      sof2_r    <= 1'b0;
      eol2_r    <= 1'b0;
      border2_r <= 1'b0;
      mode2_r   <= 3'd0;
      for (int ch = 0; ch < NCH; ch++) begin
        gx2_r[ch]     <= '0;
        gy2_r[ch]     <= '0;
        grad2_r[ch]   <= '0;
        gauss2_r[ch]  <= '0;
        centre2_r[ch] <= '0;
      end
    end else begin
      v2_r <= v1_r;
      if (v1_r) begin
        sof2_r    <= sof1_r;
        eol2_r    <= eol1_r;
        border2_r <= border1_r;
        mode2_r   <= mode1_r;
        for (int ch = 0; ch < NCH; ch++) begin
          gx2_r[ch]     <= gx_s[ch];
          gy2_r[ch]     <= gy_s[ch];
          grad2_r[ch]   <= grad_s[ch];
          gauss2_r[ch]  <= gauss_s[ch];
          centre2_r[ch] <= win_r[ch][1][1];
        end
      end
    end
  end

  logic signed [AW-1:0] sel_s [NCH];
  logic [PW-1:0]        out_data_s;

  // Stage 3: mode select, clip and border mask.
  always_comb begin
    out_data_s = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      sel_s[ch] = '0;
      case (mode2_r)
        MODE_SOBEL_X: sel_s[ch] = gx2_r[ch];
        MODE_SOBEL_Y: sel_s[ch] = gy2_r[ch];
        MODE_GRAD:    sel_s[ch] = grad2_r[ch];
        MODE_GAUSS:   sel_s[ch] = gauss2_r[ch];
        default:      sel_s[ch] = $signed({4'b0000, centre2_r[ch]});
      endcase
      if (border2_r) begin
        out_data_s[(NCH-1-ch)*DW +: DW] = '0;
      end else begin
        out_data_s[(NCH-1-ch)*DW +: DW] = DW'(clip_sat(int'(sel_s[ch]), DW));
      end
    end
  end

  // Output register; data holds between beats.
  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_VALID <= 1'b0;
      OUT_SOF   <= 1'b0;
      OUT_EOL   <= 1'b0;
      OUT_DATA  <= '0;
    end else begin
      OUT_VALID <= v2_r;
      OUT_SOF   <= v2_r & sof2_r;
      OUT_EOL   <= v2_r & eol2_r;
      if (v2_r) begin
        OUT_DATA <= out_data_s;
      end
    end
  end

endmodule

// File: tb/tb_kernel3x3_filter.sv
// Self-checking bench for kernel3x3_filter at an 8x6 frame: directed and
// randomized frames scored against an image-level reference model.
module tb_kernel3x3_filter;

  localparam int W   = 8;
  localparam int H   = 6;
  localparam int DW  = 8;
  localparam int NCH = 3;
  localparam int PW  = NCH * DW;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [2:0]    MODE = 3'd0;
  logic          IN_VALID = 1'b0;
  logic          IN_SOF = 1'b0;
  logic [PW-1:0] IN_DATA = '0;
  logic          OUT_VALID, OUT_SOF, OUT_EOL;
  logic [PW-1:0] OUT_DATA;

  kernel3x3_filter #(.IMG_W(W), .IMG_H(H), .DW(DW), .NCH(NCH)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .MODE      (MODE),
    .IN_VALID  (IN_VALID),
    .IN_SOF    (IN_SOF),
    .IN_DATA   (IN_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_SOF   (OUT_SOF),
    .OUT_EOL   (OUT_EOL),
    .OUT_DATA  (OUT_DATA)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic          sof;
    logic          eol;
    logic [PW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [PW-1:0] img [H][W];
  logic [PW-1:0] last_data = '0;
  bit            hold_chk = 1'b0;
  int            n_vec = 0;
  int            n_miss = 0;
  int            eol_cnt = 0;
  int            sof_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, want, $time);
    end
  endtask

  // Reference: output for the beat at input (x,y) of the current image.
  function automatic logic [PW-1:0] model_pix(input int x, input int y, input int mode);
    logic [PW-1:0] res;
    logic [PW-1:0] px;
    int p [3][3];
    int gx, gy, v;
    res = '0;
    if (x >= 2 && y >= 2) begin
      for (int ch = 0; ch < NCH; ch++) begin
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < 3; c++) begin
            px = img[y-2+r][x-2+c];
            p[r][c] = int'(px[(NCH-1-ch)*DW +: DW]);
          end
        end
        gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
        gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
        case (mode)
          1: v = gx;
          2: v = gy;
          3: v = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
          4: v = (p[0][0] + 2*p[0][1] + p[0][2] + 2*p[1][0] + 4*p[1][1]
                  + 2*p[1][2] + p[2][0] + 2*p[2][1] + p[2][2]) / 16;
          default: v = p[1][1];
        endcase
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        res[(NCH-1-ch)*DW +: DW] = DW'(v);
      end
    end
    return res;
  endfunction

  task automatic idle();
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    IN_SOF   = 1'b0;
    IN_DATA  = PW'($urandom());
  endtask

  task automatic fill_image(input int pat);
    int v;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        case (pat)
          0: begin v = x + 8*y; img[y][x] = {3{DW'(v)}}; end
          1: begin v = (x < 3) ? 10 : 200; img[y][x] = {3{DW'(v)}}; end
          2: begin v = (((x/2) + (y/2)) % 2 == 1) ? 255 : 0; img[y][x] = {8'd0, DW'(v), 8'd0}; end
          3: img[y][x] = {3{8'd100}};
          default: img[y][x] = PW'($urandom());
        endcase
      end
    end
  endtask

  // Drives one frame (or its first stop_at beats) and queues the expected output.
  task automatic send_frame(input int pat, input int mode_a, input int mode_b, input int switch_at,
                            input int gap_pct, input int stop_at, input bit use_sof);
    exp_t e;
    fill_image(pat);
    for (int b = 0; b < W*H && b < stop_at; b++) begin
      for (int g = 0; g < 8 && $urandom_range(99) < gap_pct; g++) idle();
      @(posedge CLK);
      #1;
      IN_VALID = 1'b1;
      IN_SOF   = use_sof && (b == 0);
      MODE     = 3'((b >= switch_at) ? mode_b : mode_a);
      IN_DATA  = img[b / W][b % W];
      e.cyc  = cyc + 3;
      e.sof  = (b == 0);
      e.eol  = ((b % W) == W - 1);
      e.data = model_pix(b % W, b / W, mode_a);
      exp_q.push_back(e);
    end
  endtask

  // Synchronous reset mid-stream; beats not yet emitted are discarded.
  task automatic do_reset();
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    IN_SOF   = 1'b0;
    RST      = 1'b1;
    while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
    @(posedge CLK);
    #1;
    RST       = 1'b0;
    last_data = '0;
    repeat (3) begin
      @(negedge CLK);
      check_val("rst_quiet_valid", {31'd0, OUT_VALID}, 32'd0);
      check_val("rst_data", {8'd0, OUT_DATA}, 32'd0);
    end
  endtask

  // Output monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (OUT_VALID === 1'b1) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_beat", {31'd0, OUT_VALID}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_val("out_data", {8'd0, OUT_DATA}, {8'd0, e.data});
          check_val("out_sof", {31'd0, OUT_SOF}, {31'd0, e.sof});
          check_val("out_eol", {31'd0, OUT_EOL}, {31'd0, e.eol});
          check_val("latency", cyc, e.cyc);
        end
        last_data = OUT_DATA;
        if (OUT_EOL === 1'b1) eol_cnt++;
        if (OUT_SOF === 1'b1) sof_cnt++;
      end else if (OUT_VALID === 1'b0 && hold_chk) begin
        check_val("hold_data", {8'd0, OUT_DATA}, {8'd0, last_data});
        check_val("idle_flags", {30'd0, OUT_SOF, OUT_EOL}, 32'd0);
      end
    end
  end

  initial begin
    int m;
    RST = 1'b1;
    repeat (3) idle();
    @(negedge CLK);
    check_val("reset_valid", {31'd0, OUT_VALID}, 32'd0);
    check_val("reset_sof", {31'd0, OUT_SOF}, 32'd0);
    check_val("reset_eol", {31'd0, OUT_EOL}, 32'd0);
    check_val("reset_data", {8'd0, OUT_DATA}, 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    hold_chk = 1'b1;

    send_frame(0, 0, 0, 999, 0, 999, 1'b1);
    send_frame(1, 1, 1, 999, 0, 999, 1'b1);
    send_frame(2, 3, 3, 999, 0, 999, 1'b1);
    send_frame(3, 4, 4, 999, 0, 999, 1'b1);
    send_frame(4, 1, 2, 20, 0, 999, 1'b1);
    send_frame(4, 2, 2, 999, 25, 999, 1'b1);
    send_frame(4, 0, 0, 999, 0, 15, 1'b1);
    m = $urandom_range(7);
    send_frame(4, m, m, 999, 30, 999, 1'b1);
    m = $urandom_range(7);
    send_frame(4, m, m, 999, 50, 3*W + 5, 1'b1);
    do_reset();

    eol_cnt = 0;
    sof_cnt = 0;
    send_frame(4, 3, 3, 999, 50, 999, 1'b0);
    repeat (8) idle();
    check_val("eol_count", eol_cnt, H);
    check_val("sof_count", sof_cnt, 32'd1);
    check_val("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
